obi_data_responder: RTL and testbench

- Configurable OBI data-bus responder, i.e. the memory-side end of the core's data_req/gnt/rvalid interface.
- Holds a word-addressed scratch RAM at BASE_ADDR, applies byte-enable writes and returns read data and err.
- Grant stall, response latency and maximum outstanding transactions are parameterised, so benches can stress the core's LSU handshake.
- Drops in beside the existing RAM model in the core TB, or behind a TB address decoder.

---
 rtl/obi_resp_pkg.sv | 23 ++
 rtl/obi_data_responder_if.sv | 23 ++
 rtl/obi_resp_delay_line.sv | 44 ++++
 rtl/obi_data_responder.sv | 170 +++++++++++++++++
 tb/tb_obi_data_responder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/obi_resp_pkg.sv
// Shared types for the OBI data responder: grant FSM states, response payload
// and the LFSR used by the optional random grant stall.
package obi_resp_pkg;

   typedef enum logic [1:0] {
      G_IDLE,
      G_STALL,
      G_READY
   } gnt_state_e;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   // x^16 + x^14 + x^13 + x^11, left-shifting Fibonacci form
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/obi_data_responder_if.sv
// OBI data-bus request/response signals between an LSU (master) and the
// memory-side responder (slave).
interface obi_data_responder_if;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/obi_resp_delay_line.sv
// Fixed-length shift register for responses; reset clears only the valid
// bits so payload flops need no reset.
module obi_resp_delay_line
   import obi_resp_pkg::*;
#(
   parameter int unsigned LENGTH = 1
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  in_valid_i,
   input  resp_t in_resp_i,
   output logic  out_valid_o,
   output resp_t out_resp_o
);

   logic [LENGTH-1:0] valid_q, valid_d;
   resp_t             resp_q [LENGTH];
   resp_t             resp_d [LENGTH];

   always_comb begin
      valid_d[0] = in_valid_i;
      resp_d[0]  = in_resp_i;
      for (int i = 1; i < LENGTH; i++) begin
         valid_d[i] = valid_q[i-1];
         resp_d[i]  = resp_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      resp_q <= resp_d;
   end

   assign out_valid_o = valid_q[LENGTH-1];
   assign out_resp_o  = resp_q[LENGTH-1];

endmodule

// File: rtl/obi_data_responder.sv
// Memory-side OBI data responder with a scratch RAM, configurable grant stall,
// response latency and outstanding limit. OBI_RESP_RANDOM_STALL_EN adds 0-3
// LFSR-driven stall cycles per request.
//
// state   | meaning
// G_IDLE  | no request being stalled; same-cycle grant when total stall is 0
// G_STALL | counting down stall_cnt; grants in the cycle it reads 0
// G_READY | grant whenever a request is present and there is room
module obi_data_responder
   import obi_resp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter logic [31:0] BASE_ADDR       = 32'h0002_0000,
   parameter int unsigned GNT_DELAY       = 0,
   parameter int unsigned RESP_DELAY      = 0,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   obi_data_responder_if.slave  bus
);

   localparam int unsigned DEPTH = 2**ADDR_WIDTH;
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned CNT_W = $clog2(GNT_DELAY + 4) + 1;
   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   gnt_state_e        state_q, state_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  stall_total;
   logic [OUT_W-1:0]  outstanding_q, outstanding_d;
   logic [31:0]       ram_q [DEPTH];
   logic [31:0]       ram_d [DEPTH];

   logic                  ready_now;
   logic                  has_room;
   logic                  accept;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] idx;
   resp_t                 resp_in;
   resp_t                 resp_out;
   logic                  resp_valid;
   logic                  unused_addr;

   assign unused_addr = ^bus.addr_i[1:0];

`ifdef OBI_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign stall_total = CNT_W'(GNT_DELAY) + CNT_W'(lfsr_q[1:0]);
`else
   logic [15:0] unused_seed;

   assign unused_seed = LFSR_SEED;
   assign stall_total = CNT_W'(GNT_DELAY);
`endif

   // A response leaving this cycle frees its slot for a same-cycle accept.
   assign has_room = (outstanding_q < MAX_OUT) || resp_valid;

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      ready_now   = 1'b0;
      unique case (state_q)
         G_IDLE: begin
            if (bus.req_i) begin
               if (stall_total == '0) begin
                  ready_now = 1'b1;
               end else begin
                  stall_cnt_d = stall_total - CNT_W'(1);
                  state_d     = G_STALL;
               end
            end
         end
         G_STALL: begin
            if (stall_cnt_q == '0) begin
               ready_now = 1'b1;
            end else begin
               stall_cnt_d = stall_cnt_q - CNT_W'(1);
            end
         end
         G_READY: ready_now = 1'b1;
         default: state_d = G_IDLE;
      endcase
      accept = ready_now && bus.req_i && has_room && !rst_i;
      // After an accept the next cycle's req is a fresh request.
      if (ready_now) begin
         state_d = (bus.req_i && !accept) ? G_READY : G_IDLE;
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      unique case ({accept, resp_valid})
         2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
         2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_comb begin
      hit = (bus.addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
      idx = bus.addr_i[ADDR_WIDTH+1:2];
      resp_in.err   = !hit;
      resp_in.rdata = (hit && !bus.we_i) ? ram_q[idx] : 32'h0;
      ram_d = ram_q;
      if (accept && bus.we_i && hit) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.be_i[k]) begin
               ram_d[idx][8*k +: 8] = bus.wdata_i[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= G_IDLE;
         stall_cnt_q   <= '0;
         outstanding_q <= '0;
         ram_q         <= '{default: '0};
      end else begin
         state_q       <= state_d;
         stall_cnt_q   <= stall_cnt_d;
         outstanding_q <= outstanding_d;
         ram_q         <= ram_d;
      end
   end

   obi_resp_delay_line #(
      .LENGTH (RESP_DELAY + 1)
   ) u_delay (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (accept),
      .in_resp_i   (resp_in),
      .out_valid_o (resp_valid),
      .out_resp_o  (resp_out)
   );

   assign bus.gnt_o    = accept;
   assign bus.rvalid_o = resp_valid;
   assign bus.rdata_o  = resp_valid ? resp_out.rdata : 32'h0;
   assign bus.err_o    = resp_valid ? resp_out.err : 1'b0;

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (accept && !resp_valid) |-> (outstanding_q < MAX_OUT));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (resp_valid && !accept) |-> (outstanding_q != '0));
   a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (bus.req_i && !bus.gnt_o) |=> (bus.req_i && $stable(bus.addr_i) && $stable(bus.we_i)
                                     && $stable(bus.be_i) && $stable(bus.wdata_i)));
`endif

endmodule

// File: tb/tb_obi_data_responder.sv
// Scoreboard bench for obi_data_responder: four instances with different
// grant/response timing, expected responses queued at accept time.
module tb_obi_data_responder;

   localparam int GD_P [4] = '{0, 3, 0, 0};
   localparam int RD_P [4] = '{0, 2, 4, 3};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic        clk;
   logic [3:0]  rst;
   logic [3:0]  req;
   logic [3:0]  we;
   logic [31:0] addr_v  [4];
   logic [3:0]  be_v    [4];
   logic [31:0] wdata_v [4];
   logic [3:0]  gnt;
   logic [3:0]  rvalid;
   logic [3:0]  err_v;
   logic [31:0] rdata_v [4];

   exp_t sb [4][$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      obi_data_responder_if bus ();

      assign bus.req_i   = req[g];
      assign bus.we_i    = we[g];
      assign bus.addr_i  = addr_v[g];
      assign bus.be_i    = be_v[g];
      assign bus.wdata_i = wdata_v[g];
      assign gnt[g]      = bus.gnt_o;
      assign rvalid[g]   = bus.rvalid_o;
      assign err_v[g]    = bus.err_o;
      assign rdata_v[g]  = bus.rdata_o;

      obi_data_responder #(
         .GNT_DELAY  (GD_P[g]),
         .RESP_DELAY (RD_P[g])
      ) u_dut (
         .clk_i (clk),
         .rst_i (rst[g]),
         .bus   (bus.slave)
      );

      exp_t mon_e;
      always @(negedge clk) begin
         if (rvalid[g]) begin
            tests++;
            if (sb[g].size() == 0) begin
               fails++;
               $display("FAIL unexpected_rvalid dut%0d cyc=%0d rdata=%h err=%0d, required no response",
                        g, cyc, rdata_v[g], err_v[g]);
            end else begin
               mon_e = sb[g].pop_front();
               if (rdata_v[g] !== mon_e.rdata || err_v[g] !== mon_e.err || cyc != mon_e.due) begin
                  fails++;
                  $display("FAIL resp dut%0d: got rdata=%h err=%0d cyc=%0d, required rdata=%h err=%0d cyc=%0d",
                           g, rdata_v[g], err_v[g], cyc, mon_e.rdata, mon_e.err, mon_e.due);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
      tests++;
      if (act !== req_val) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req_val);
      end
   endtask

   task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                        input int ewait);
      int   waits;
      bit   got;
      exp_t e;
      waits = 0;
      got   = 1'b0;
      req[g] = 1'b1; we[g] = w; addr_v[g] = a; be_v[g] = b; wdata_v[g] = wd;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt[g]) begin
            got = 1'b1;
            break;
         end
         waits++;
      end
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL gnt_timeout dut%0d addr=%h: no grant after %0d cycles, required %0d",
                  g, a, waits, ewait);
      end else begin
         if (waits != ewait) begin
            fails++;
            $display("FAIL gnt_wait dut%0d addr=%h: got %0d stall cycles, required %0d",
                     g, a, waits, ewait);
         end
         e.rdata = erd;
         e.err   = eerr;
         e.due   = cyc + 1 + RD_P[g];
         sb[g].push_back(e);
      end
      @(posedge clk);
      #1;
      req[g] = 1'b0;
   endtask

   task automatic wait_idle(input int g);
      for (int i = 0; i < 100 && sb[g].size() != 0; i++) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst = 4'hF;
      req = '0;
      we  = '0;
      for (int g = 0; g < 4; g++) begin
         addr_v[g] = '0; be_v[g] = '0; wdata_v[g] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      req[0] = 1'b1;
      @(negedge clk);
      check("rst_gnt_forced_low", {31'h0, gnt[0]}, 32'h0);
      check("rst_rvalid", {31'h0, rvalid[0]}, 32'h0);
      check("rst_rdata", rdata_v[0], 32'h0);
      check("rst_err", {31'h0, err_v[0]}, 32'h0);
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 4'h0;

      // Default timing: same-cycle grant, 1-cycle response
      issue(0, 1, 32'h0002_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0);
      issue(0, 0, 32'h0002_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 0, 0);
      issue(0, 1, 32'h0002_0010, 4'b0010, 32'h0000_5500, 32'h0, 0, 0);
      issue(0, 0, 32'h0002_0010, 4'hF, 32'h0,         32'hDEAD_55EF, 0, 0);
      issue(0, 1, 32'h0002_0010, 4'h0, 32'hFFFF_FFFF, 32'h0, 0, 0);
      issue(0, 0, 32'h0002_0013, 4'hF, 32'h0,         32'hDEAD_55EF, 0, 0);
      issue(0, 1, 32'h0003_0000, 4'hF, 32'h1111_1111, 32'h0, 1, 0);
      issue(0, 0, 32'h0003_0000, 4'hF, 32'h0,         32'h0, 1, 0);
      issue(0, 0, 32'h0002_0000, 4'hF, 32'h0,         32'h0, 0, 0);
      issue(0, 1, 32'h0002_03FC, 4'hF, 32'h1234_5678, 32'h0, 0, 0);
      issue(0, 1, 32'h0002_03FC, 4'b1000, 32'hAB00_0000, 32'h0, 0, 0);
      issue(0, 0, 32'h0002_03FC, 4'hF, 32'h0,         32'hAB34_5678, 0, 0);
      issue(0, 0, 32'h0002_0400, 4'hF, 32'h0,         32'h0, 1, 0);
      wait_idle(0);

      // GNT_DELAY=3, RESP_DELAY=2
      issue(1, 0, 32'h0002_0004, 4'hF, 32'h0,         32'h0, 0, 3);
      issue(1, 1, 32'h0002_000C, 4'hF, 32'h0BAD_F00D, 32'h0, 0, 3);
      issue(1, 0, 32'h0002_000C, 4'hF, 32'h0,         32'h0BAD_F00D, 0, 3);
      wait_idle(1);

      // MAX_OUTSTANDING=2, RESP_DELAY=4: third request waits for first rvalid
      issue(2, 1, 32'h0002_0040, 4'hF, 32'h0000_00A1, 32'h0, 0, 0);
      issue(2, 1, 32'h0002_0044, 4'hF, 32'h0000_00B2, 32'h0, 0, 0);
      issue(2, 1, 32'h0002_0048, 4'hF, 32'h0000_00C3, 32'h0, 0, 3);
      wait_idle(2);
      issue(2, 0, 32'h0002_0040, 4'hF, 32'h0, 32'h0000_00A1, 0, 0);
      issue(2, 0, 32'h0002_0044, 4'hF, 32'h0, 32'h0000_00B2, 0, 0);
      issue(2, 0, 32'h0002_0048, 4'hF, 32'h0, 32'h0000_00C3, 0, 3);
      wait_idle(2);

      // RESP_DELAY=3: reset one cycle after an accept discards its response
      issue(3, 1, 32'h0002_0020, 4'hF, 32'hCAFE_F00D, 32'h0, 0, 0);
      issue(3, 0, 32'h0002_0020, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 0);
      wait_idle(3);
      req[3] = 1'b1; we[3] = 1'b0; addr_v[3] = 32'h0002_0020; be_v[3] = 4'hF;
      @(negedge clk);
      check("discard_accept_gnt", {31'h0, gnt[3]}, 32'h1);
      @(posedge clk);
      #1;
      rst[3] = 1'b1;
      @(negedge clk);
      check("midop_rst_gnt_low", {31'h0, gnt[3]}, 32'h0);
      @(posedge clk);
      #1;
      req[3] = 1'b0;
      @(posedge clk);
      #1;
      rst[3] = 1'b0;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (rvalid[3]) seen++;
      end
      check("no_rvalid_after_rst", seen, 32'h0);
      check("outstanding_after_rst", {30'h0, g_dut[3].u_dut.outstanding_q}, 32'h0);
      @(posedge clk);
      #1;
      issue(3, 0, 32'h0002_0020, 4'hF, 32'h0, 32'h0, 0, 0);
      wait_idle(3);

      for (int g = 0; g < 4; g++) begin
         check("scoreboard_drained", sb[g].size(), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
